// File: rtl/text_overlay_sched.sv
// Frame-rate scheduler for the text overlay: SHOW/BLINK/HIDE message sequencing and cell-position bounce.
// Optional position bounce is built when TEXT_SCHED_BOUNCE_EN is defined; otherwise the origin is fixed.
module text_overlay_sched #(
    parameter int NUM_MSGS     = 4,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 64,
    parameter int GAP_FRAMES   = 30,
    parameter int STEP_FRAMES  = 2,
    parameter int MAX_X        = 33,
    parameter int MAX_Y        = 51,
    parameter int INIT_X       = 18,
    parameter int INIT_Y       = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_start,
    output logic [6:0] cell_x,
    output logic [5:0] cell_y,
    output logic [1:0] msg_sel,
    output logic       text_visible,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHOW, BLINK, HIDE} state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);
    localparam logic [1:0] MSG_LAST   = 2'(NUM_MSGS - 1);

    generate
        if (NUM_MSGS < 1 || NUM_MSGS > 4 || STEP_FRAMES < 1 || STEP_FRAMES > 255 ||
            MAX_X < 1 || MAX_X > 127 || MAX_Y < 1 || MAX_Y > 63 ||
            INIT_X > MAX_X || INIT_Y > MAX_Y) begin : g_bad_cfg
            $error("text_overlay_sched: parameter out of range");
        end
    endgenerate

    state_t     state;
    logic [7:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            frame_cnt    <= 8'd0;
            msg_sel      <= 2'd0;
            text_visible <= 1'b0;
            busy         <= 1'b0;
        end else if (!enable) begin
            // msg_sel deliberately holds so the sequence resumes on the same message
            state        <= IDLE;
            frame_cnt    <= 8'd0;
            text_visible <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state        <= SHOW;
                    frame_cnt    <= 8'd0;
                    text_visible <= 1'b1;
                    busy         <= 1'b1;
                end
                SHOW: if (frame_start) begin
                    if (frame_cnt == HOLD_LAST) begin
                        state     <= BLINK;
                        frame_cnt <= 8'd0;
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                BLINK: if (frame_start) begin
                    if (frame_cnt == BLINK_LAST) begin
                        state        <= HIDE;
                        frame_cnt    <= 8'd0;
                        text_visible <= 1'b0;
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                        if (frame_cnt[2:0] == 3'd7)
                            text_visible <= ~text_visible;
                    end
                end
                HIDE: if (frame_start) begin
                    if (frame_cnt == GAP_LAST) begin
                        state        <= SHOW;
                        frame_cnt    <= 8'd0;
                        text_visible <= 1'b1;
                        msg_sel      <= (msg_sel == MSG_LAST) ? 2'd0 : msg_sel + 2'd1;
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TEXT_SCHED_BOUNCE_EN
    localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);

    logic       dir_x;
    logic       dir_y;
    logic [7:0] step_cnt;

    // dir = 1 means moving toward max; reflect off either wall without leaving [0, max]
    function automatic logic bounce_dir(input logic [6:0] pos, input logic dir, input logic [6:0] max_pos);
        if (dir && pos >= max_pos)
            return 1'b0;
        else if (!dir && pos == 7'd0)
            return 1'b1;
        else
            return dir;
    endfunction

    function automatic logic [6:0] bounce_pos(input logic [6:0] pos, input logic dir, input logic [6:0] max_pos);
        return bounce_dir(pos, dir, max_pos) ? pos + 7'd1 : pos - 7'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cell_x   <= 7'(INIT_X);
            cell_y   <= 6'(INIT_Y);
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
            step_cnt <= 8'd0;
        end else if (!enable) begin
            step_cnt <= 8'd0;
        end else if (state != IDLE && frame_start) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt <= 8'd0;
                cell_x   <= bounce_pos(cell_x, dir_x, 7'(MAX_X));
                dir_x    <= bounce_dir(cell_x, dir_x, 7'(MAX_X));
                cell_y   <= 6'(bounce_pos({1'b0, cell_y}, dir_y, 7'(MAX_Y)));
                dir_y    <= bounce_dir({1'b0, cell_y}, dir_y, 7'(MAX_Y));
            end else begin
                step_cnt <= step_cnt + 8'd1;
            end
        end
    end
`else
    assign cell_x = 7'(INIT_X);
    assign cell_y = 6'(INIT_Y);
`endif

endmodule

// File: tb/tb_text_overlay_sched.sv
// Bench for text_overlay_sched: reset/table vectors, multi-cycle corner sequences, random run vs. a pulse-count model.
module tb_text_overlay_sched;

    localparam int HOLD  = 4;
    localparam int BLINK = 16;
    localparam int GAP   = 2;
    localparam int STEP  = 1;
    localparam int NMSG  = 3;
    localparam int MAXX  = 33;
    localparam int MAXY  = 51;
    localparam int IX    = 18;
    localparam int IY    = 12;
    localparam int CYC   = HOLD + BLINK + GAP;
`ifdef TEXT_SCHED_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       frame_start = 1'b0;
    logic [6:0] cell_x;
    logic [5:0] cell_y;
    logic [1:0] msg_sel;
    logic       text_visible;
    logic       busy;

    always #5 clk = ~clk;

    text_overlay_sched #(
        .NUM_MSGS(NMSG), .HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK), .GAP_FRAMES(GAP),
        .STEP_FRAMES(STEP), .MAX_X(MAXX), .MAX_Y(MAXY), .INIT_X(IX), .INIT_Y(IY)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
        .cell_x(cell_x), .cell_y(cell_y), .msg_sel(msg_sel),
        .text_visible(text_visible), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: counts accepted pulses per enabled session and derives everything from those counts
    bit m_active = 1'b0;
    int m_p      = 0;
    int m_steps  = 0;
    int m_base   = 0;

    function automatic int tri_pos(input int init, input int steps, input int maxv);
        int u;
        u = (init + steps) % (2 * maxv);
        return (u <= maxv) ? u : 2 * maxv - u;
    endfunction

    function automatic int exp_x(input int steps);
        return BOUNCE ? tri_pos(IX, steps, MAXX) : IX;
    endfunction

    function automatic int exp_y(input int steps);
        return BOUNCE ? tri_pos(IY, steps, MAXY) : IY;
    endfunction

    function automatic int vis_of(input int p);
        int k;
        k = p % CYC;
        if (k < HOLD) return 1;
        if (k < HOLD + BLINK) return (((k - HOLD) / 8) % 2 == 0) ? 1 : 0;
        return 0;
    endfunction

    task automatic model_step(input bit rst, input bit en, input bit fs);
        if (rst) begin
            m_active = 1'b0; m_p = 0; m_steps = 0; m_base = 0;
        end else if (!en) begin
            if (m_active) begin
                m_steps = m_steps + m_p / STEP;
                m_base  = (m_base + m_p / CYC) % NMSG;
            end
            m_active = 1'b0;
            m_p = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_p = 0;
        end else if (fs) begin
            m_p++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int steps;
        steps = m_steps + (m_active ? m_p / STEP : 0);
        check({tag, ".visible"}, int'(text_visible), m_active ? vis_of(m_p) : 0);
        check({tag, ".busy"},    int'(busy), int'(m_active));
        check({tag, ".msg"},     int'(msg_sel), (m_base + (m_active ? m_p / CYC : 0)) % NMSG);
        check({tag, ".x"},       int'(cell_x), exp_x(steps));
        check({tag, ".y"},       int'(cell_y), exp_y(steps));
    endtask

    task automatic cycle(input bit rst, input bit en, input bit fs);
        reset = rst; enable = en; frame_start = fs;
        @(posedge clk);
        model_step(rst, en, fs);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic pulses(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, 1'b1);
            check_model(tag);
        end
    endtask

    typedef struct {
        bit en;
        bit fs;
        int vis;
        int busy;
        int msg;
        int x;
        int y;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t v;
        int   exp_msg[4];
        exp_msg = '{0, 1, 2, 0};

        // Table: enable from reset, one idle hold, then 22 pulses through SHOW/BLINK/HIDE back to SHOW
        v = '{en: 1'b1, fs: 1'b0, vis: 1, busy: 1, msg: 0, x: IX, y: IY};
        vecs.push_back(v);
        vecs.push_back(v);
        for (int j = 1; j <= CYC; j++) begin
            v.fs   = 1'b1;
            v.vis  = (j <= 11 || j == CYC) ? 1 : 0;
            v.msg  = (j == CYC) ? 1 : 0;
            v.x    = exp_x(j);
            v.y    = exp_y(j);
            vecs.push_back(v);
            if (j == 12 || j == 3) begin
                v.fs = 1'b0;
                vecs.push_back(v);
            end
        end

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        check("reset.visible", int'(text_visible), 0);
        check("reset.busy",    int'(busy), 0);
        check("reset.msg",     int'(msg_sel), 0);
        check("reset.x",       int'(cell_x), IX);
        check("reset.y",       int'(cell_y), IY);

        foreach (vecs[i]) begin
            cycle(1'b0, vecs[i].en, vecs[i].fs);
            check($sformatf("vec%0d.visible", i), int'(text_visible), vecs[i].vis);
            check($sformatf("vec%0d.busy", i),    int'(busy), vecs[i].busy);
            check($sformatf("vec%0d.msg", i),     int'(msg_sel), vecs[i].msg);
            check($sformatf("vec%0d.x", i),       int'(cell_x), vecs[i].x);
            check($sformatf("vec%0d.y", i),       int'(cell_y), vecs[i].y);
        end

        // Message wrap over three full cycles
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("wrap%0d.msg", c), int'(msg_sel), exp_msg[c]);
            if (c < 3) pulses(CYC, "wrap");
        end

        // Wall reflections: x hits 33 after 15 steps, y reaches 0 after 90 steps
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        pulses(15, "bx");
        check("bounce.x_at_max", int'(cell_x), BOUNCE ? 33 : IX);
        pulses(1, "bx");
        check("bounce.x_reflect", int'(cell_x), BOUNCE ? 32 : IX);
        pulses(74, "by");
        check("bounce.y_at_zero", int'(cell_y), BOUNCE ? 0 : IY);
        pulses(1, "by");
        check("bounce.y_reflect", int'(cell_y), BOUNCE ? 1 : IY);

        // Disable with a simultaneous pulse in BLINK, then re-enable and require a full HOLD
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        pulses(HOLD + 3, "pre");
        cycle(1'b0, 1'b0, 1'b1);
        check("dis.visible", int'(text_visible), 0);
        check("dis.busy",    int'(busy), 0);
        check("dis.x",       int'(cell_x), BOUNCE ? 25 : IX);
        check("dis.msg",     int'(msg_sel), 0);
        cycle(1'b0, 1'b0, 1'b1);
        check_model("idle_pulse");
        cycle(1'b0, 1'b1, 1'b1);
        check("reen.visible", int'(text_visible), 1);
        check("reen.busy",    int'(busy), 1);
        pulses(HOLD + 7, "reen");
        check("reen.still_visible", int'(text_visible), 1);
        pulses(1, "reen");
        check("reen.blink_off", int'(text_visible), 0);
        check("reen.x", int'(cell_x), BOUNCE ? 29 : IX);

        // Reset in the middle of BLINK restores everything at once
        cycle(1'b1, 1'b1, 1'b1);
        check("midrst.visible", int'(text_visible), 0);
        check("midrst.busy",    int'(busy), 0);
        check("midrst.msg",     int'(msg_sel), 0);
        check("midrst.x",       int'(cell_x), IX);
        check("midrst.y",       int'(cell_y), IY);

        // Long run without reset so message and position state accumulate
        cycle(1'b0, 1'b1, 1'b0);
        pulses(200, "long");

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit r, e, f;
            r = ($urandom_range(0, 999) < 2);
            e = ($urandom_range(0, 99) >= 4);
            f = ($urandom_range(0, 99) < 35);
            cycle(r, e, f);
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
